// File: rtl/divider_if.sv
// ---------------------------------------------------------------------------
// divider_if -- request/result bundle for divider_32by16.
//
// Signals (N = divisor/quotient/remainder width, dividend is 2N bits):
//   start     : request to begin a division (master -> slave)
//   dividend  : 2N-bit unsigned dividend        (master -> slave)
//   divisor   : N-bit unsigned divisor          (master -> slave)
//   busy      : division in progress            (slave -> master)
//   done      : one-cycle result-valid pulse    (slave -> master)
//   quotient  : N-bit unsigned quotient         (slave -> master)
//   remainder : N-bit unsigned remainder        (slave -> master)
//   error     : divide-by-zero / overflow flag  (slave -> master)
// ---------------------------------------------------------------------------
interface divider_if #(
   parameter int N = 16
);
   logic             start;
   logic [2*N-1:0]   dividend;
   logic [N-1:0]     divisor;
   logic             busy;
   logic             done;
   logic [N-1:0]     quotient;
   logic [N-1:0]     remainder;
   logic             error;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, error
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, error
   );
endinterface

// File: rtl/divider_32by16.sv
// ---------------------------------------------------------------------------
// divider_32by16 -- sequential restoring radix-2 divider, 2N-bit / N-bit.
//
// Ports:
//   clk   : single clock, all state changes on its rising edge
//   rst_n : synchronous active-low reset
//   bus   : divider_if.slave (start, dividend, divisor in;
//           busy, done, quotient, remainder, error out)
//
// Timing: a start sampled in IDLE at edge k enters CALC at edge k+1, runs
// N steps and shows done (with busy) during the cycle after edge k+N+1.
//
// Optional feature: define DIV_ERR_CHECK_EN to compile in operand checking.
// Illegal operands (divisor == 0 or dividend[2N-1:N] >= divisor) then skip
// CALC, going straight to DONE with error=1, quotient=all ones and
// remainder=dividend[N-1:0]. Without the macro error is tied to 0 and every
// request takes the full CALC path.
// ---------------------------------------------------------------------------
module divider_32by16 #(
   parameter int N = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   divider_if.slave  bus
);

   localparam int CNT_W = $clog2(N + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic             req_q;      // start captured in IDLE, acted on next cycle
   logic [N-1:0]     part_r;     // partial remainder (upper dividend half)
   logic [N-1:0]     shreg_r;    // lower dividend bits out, quotient bits in
   logic [N-1:0]     dvs_r;
   logic [CNT_W-1:0] step_cnt;
   logic [N-1:0]     quot_r;
   logic [N-1:0]     rem_r;

   logic             take;
   logic [N:0]       shifted;
   logic             ge;
   logic [N-1:0]     part_nxt;
   logic [N-1:0]     shreg_nxt;

   // NOTE: start is registered before the FSM acts on it, so operands are
   // captured from the pins at edge k and the FSM leaves IDLE at edge k+1.
   // Re-capture is blocked while a captured request is pending.
   assign take = (state == IDLE) && bus.start && !req_q;

   // One restoring step: bring the next dividend bit into an (N+1)-bit
   // partial remainder, subtract the divisor when it fits.
   // NOTE: every always_comb output gets a value on every path; a missing
   // default would infer a latch.
   always_comb begin
      shifted   = {part_r, shreg_r[N-1]};
      ge        = (shifted >= {1'b0, dvs_r});
      part_nxt  = shifted[N-1:0];
      if (ge) begin
         part_nxt = N'(shifted - {1'b0, dvs_r});
      end
      shreg_nxt = {shreg_r[N-2:0], ge};
   end

`ifdef DIV_ERR_CHECK_EN
   logic op_err;
   logic err_r;

   // Divisor zero, or the quotient would not fit in N bits.
   assign op_err = (dvs_r == '0) || (part_r >= dvs_r);
`endif

   // NOTE: reset is synchronous; datapath registers are cleared together
   // with the outputs so the visible results read 0 straight after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         req_q    <= 1'b0;
         part_r   <= '0;
         shreg_r  <= '0;
         dvs_r    <= '0;
         step_cnt <= '0;
         quot_r   <= '0;
         rem_r    <= '0;
`ifdef DIV_ERR_CHECK_EN
         err_r    <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so
         // every register here sees the pre-edge values of the others.
         req_q <= take;

         if (take) begin
            part_r  <= bus.dividend[2*N-1:N];
            shreg_r <= bus.dividend[N-1:0];
            dvs_r   <= bus.divisor;
         end

         case (state)
            IDLE: begin
               if (req_q) begin
                  step_cnt <= '0;
`ifdef DIV_ERR_CHECK_EN
                  if (op_err) begin
                     state  <= DONE;
                     quot_r <= '1;
                     rem_r  <= shreg_r;
                     err_r  <= 1'b1;
                  end else begin
                     state  <= CALC;
                  end
`else
                  state <= CALC;
`endif
               end
            end

            CALC: begin
               part_r   <= part_nxt;
               shreg_r  <= shreg_nxt;
               step_cnt <= step_cnt + 1'b1;
               if (step_cnt == CNT_W'(N - 1)) begin
                  state  <= DONE;
                  quot_r <= shreg_nxt;
                  rem_r  <= part_nxt;
`ifdef DIV_ERR_CHECK_EN
                  err_r  <= 1'b0;
`endif
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = (state == CALC) || (state == DONE);
   assign bus.done      = (state == DONE);
   assign bus.quotient  = quot_r;
   assign bus.remainder = rem_r;
`ifdef DIV_ERR_CHECK_EN
   assign bus.error     = err_r;
`else
   assign bus.error     = 1'b0;
`endif

endmodule

// File: tb/tb_divider_32by16.sv
// ---------------------------------------------------------------------------
// tb_divider_32by16 -- self-checking bench for divider_32by16 (N = 16).
// Expected results come from an arithmetic model and go through a
// scoreboard queue: pushed when a start is driven, popped on done.
// Latency is counted in cycles from the start cycle: the done cycle is
// cycle N+2 on the CALC path and cycle 2 on the operand-error path.
// Compile with DIV_ERR_CHECK_EN to exercise the error-checking build.
// ---------------------------------------------------------------------------
module tb_divider_32by16;

   localparam int N        = 16;
   localparam int LAT_CALC = N + 2;
   localparam int LAT_ERR  = 2;
   localparam int MAX_WAIT = 60;
`ifdef DIV_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        err;
      int          lat;
      bit          chk_qr;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   divider_if #(.N(N)) bus ();

   divider_32by16 #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_compared   = 0;
   int   n_mismatched = 0;
   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] dvd,
                                  input logic [15:0] dvs);
      exp_t e;
      e.q      = '0;
      e.r      = '0;
      e.err    = 1'b0;
      e.lat    = LAT_CALC;
      e.chk_qr = 1'b1;
      if (dvs == 16'h0 || dvd[31:16] >= dvs) begin
         if (ERR_EN) begin
            e.q   = 16'hFFFF;
            e.r   = dvd[15:0];
            e.err = 1'b1;
            e.lat = LAT_ERR;
         end else begin
            e.chk_qr = 1'b0;
         end
      end else begin
         e.q = 16'(dvd / {16'h0, dvs});
         e.r = 16'(dvd % {16'h0, dvs});
      end
      return e;
   endfunction

   // Called at a negedge; start is sampled at the following posedge.
   task automatic start_div(input logic [31:0] dvd, input logic [15:0] dvs);
      sb.push_back(model(dvd, dvs));
      bus.start    = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dvs;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Full transaction; returns at the negedge of the IDLE cycle after done,
   // so a following call issues its start back-to-back.
   task automatic run_div(input string tag, input logic [31:0] dvd,
                          input logic [15:0] dvs, input bit glitch);
      int   cyc;
      exp_t e;
      start_div(dvd, dvs);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (glitch && cyc == 4) begin
            bus.start    = 1'b1;
            bus.dividend = 32'h0001_2345;
            bus.divisor  = 16'h0002;
         end else if (glitch && cyc == 5) begin
            bus.start = 1'b0;
         end
         if (cyc == N / 2 && sb[0].lat == LAT_CALC) begin
            check({tag, "_busy_calc"}, 32'(bus.busy), 32'd1);
         end
      end while (!bus.done && cyc < MAX_WAIT);
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
      check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
      check({tag, "_error"}, 32'(bus.error), 32'(e.err));
      if (e.chk_qr) begin
         check({tag, "_quotient"}, 32'(bus.quotient), 32'(e.q));
         check({tag, "_remainder"}, 32'(bus.remainder), 32'(e.r));
      end
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
      if (e.chk_qr) begin
         check({tag, "_quotient_hold"}, 32'(bus.quotient), 32'(e.q));
      end
   endtask

   initial begin
      int          dones;
      int          dvs_i;
      logic [31:0] dvd_r;

      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;

      // Reset held for two edges.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_error", 32'(bus.error), 32'd0);
      check("rst_quotient", 32'(bus.quotient), 32'h0);
      check("rst_remainder", 32'(bus.remainder), 32'h0);

      // Start in the first cycle after reset release.
      rst_n = 1'b1;
      run_div("nominal", 32'h003C_77DD, 16'h0141, 1'b0);
      run_div("max_a", 32'hFFFE_0001, 16'hFFFF, 1'b0);
      run_div("max_b", 32'h0000_FFFF, 16'h0001, 1'b0);
      run_div("zero_dvd", 32'h0000_0000, 16'h1234, 1'b0);

      // Illegal operands: error path with checking, CALC latency without.
      run_div("div_zero", 32'h1234_5678, 16'h0000, 1'b0);
      run_div("overflow", 32'h0001_0000, 16'h0001, 1'b0);
      run_div("after_err", 32'h0000_1000, 16'h0010, 1'b0);

      // Random legal operands.
      for (int i = 0; i < 6; i++) begin
         dvs_i = $urandom_range(65535, 1);
         dvd_r = {16'($urandom_range(dvs_i - 1, 0)), 16'($urandom)};
         run_div($sformatf("rand%0d", i), dvd_r, 16'(dvs_i), 1'b0);
      end

      // Start pulsed with new operands mid-CALC must be ignored.
      run_div("glitch", 32'h0ABC_DEF0, 16'h1357, 1'b0 | 1'b1);
      dones = 0;
      repeat (N + 4) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("glitch_no_extra_done", 32'(dones), 32'd0);

      // Reset for one edge around CALC step 8 abandons the division.
      start_div(32'h00FF_1234, 16'h4321);
      dones = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_no_done", 32'(dones), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_quotient", 32'(bus.quotient), 32'h0);
      check("abort_remainder", 32'(bus.remainder), 32'h0);
      void'(sb.pop_front());
      run_div("after_abort", 32'h3039_0000, 16'hFEDC, 1'b0);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_compared, n_mismatched);
      $finish;
   end

endmodule
